// File: rtl/gpio_input_filter.sv
// gpio_input_filter: per-pin input conditioning for the GPIO peripheral.
// Each raw pad input passes through a two-flop synchroniser. It is then
// either forwarded directly (bypass) or debounced by a per-pin stability
// counter that advances on ticks of a shared prescaler. The accepted level
// drives gpio_o. A registered one-cycle change pulse is raised on the same
// edge on which gpio_o changes.

module gpio_input_filter #(
    // Pin count; must match the GPIO peripheral instance this block feeds.
    parameter int unsigned NrGPIOs    = 32,
    parameter int unsigned CntWidth   = 8,
    parameter int unsigned PrescWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NrGPIOs-1:0]    pad_i,
    input  logic [NrGPIOs-1:0]    filt_en_i,
    input  logic [CntWidth-1:0]   threshold_i,
    input  logic [PrescWidth-1:0] prescale_i,
    output logic [NrGPIOs-1:0]    gpio_o,
    output logic [NrGPIOs-1:0]    change_o
);

    localparam logic [PrescWidth-1:0] PrescOne = {{(PrescWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth:0]     CntOne   = {{CntWidth{1'b0}}, 1'b1};

    logic [NrGPIOs-1:0]    s1_q, s1_d;
    logic [NrGPIOs-1:0]    s2_q, s2_d;
    logic [NrGPIOs-1:0]    stable_q, stable_d;
    logic [NrGPIOs-1:0]    change_q, change_d;
    logic [PrescWidth-1:0] presc_q, presc_d;
    logic [CntWidth-1:0]   cnt_q [NrGPIOs];
    logic [CntWidth-1:0]   cnt_d [NrGPIOs];
    logic [CntWidth:0]     cnt_inc_s [NrGPIOs];
    logic [CntWidth:0]     thr_eff_s;
    logic                  tick_s;

    // Synchroniser next-state: plain two-stage shift of the pad inputs.
    always_comb begin
        s1_d = pad_i;
        s2_d = s1_q;
    end

    // Effective threshold widened by one bit; a programmed 0 behaves as 1.
    always_comb begin
        if (threshold_i == {CntWidth{1'b0}}) begin
            thr_eff_s = CntOne;
        end else begin
            thr_eff_s = {1'b0, threshold_i};
        end
    end

    // Shared prescaler: >= compare so a lowered reload wraps at once.
    always_comb begin
        tick_s = (presc_q >= prescale_i);
        if (tick_s) begin
            presc_d = {PrescWidth{1'b0}};
        end else begin
            presc_d = presc_q + PrescOne;
        end
    end

    // Per-pin filter decision: bypass, reset count, hold, accept or count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NrGPIOs; i++) begin
            cnt_inc_s[i] = {1'b0, cnt_q[i]} + CntOne;
            cnt_d[i]     = cnt_q[i];
            if (!filt_en_i[i]) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = {CntWidth{1'b0}};
            end else if (s2_q[i] == stable_q[i]) begin
                cnt_d[i]    = {CntWidth{1'b0}};
            end else if (!tick_s) begin
                cnt_d[i]    = cnt_q[i];
            end else if (cnt_inc_s[i] >= thr_eff_s) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = {CntWidth{1'b0}};
            end else begin
                cnt_d[i]    = cnt_inc_s[i][CntWidth-1:0];
            end
        end
        change_d = stable_d ^ stable_q;
    end

    // State registers; synchronous reset clears everything including the synchroniser.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q     <= {NrGPIOs{1'b0}};
            s2_q     <= {NrGPIOs{1'b0}};
            stable_q <= {NrGPIOs{1'b0}};
            change_q <= {NrGPIOs{1'b0}};
            presc_q  <= {PrescWidth{1'b0}};
            for (int i = 0; i < NrGPIOs; i++) begin
                cnt_q[i] <= {CntWidth{1'b0}};
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            change_q <= change_d;
            presc_q  <= presc_d;
            for (int i = 0; i < NrGPIOs; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_o   = stable_q;
    assign change_o = change_q;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Directed testbench for gpio_input_filter with 4 pins.
// Each vector: inputs are applied, one rising edge occurs, and gpio_o/change_o
// are compared 1 time unit after that edge.

module tb_gpio_input_filter;

    localparam int N = 4;

    typedef struct packed {
        logic         rst;
        logic [N-1:0] pad;
        logic [N-1:0] en;
        logic [7:0]   thr;
        logic [15:0]  presc;
        logic [N-1:0] exp_gpio;
        logic [N-1:0] exp_chg;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [N-1:0] pad_i;
    logic [N-1:0] filt_en_i;
    logic [7:0]   threshold_i;
    logic [15:0]  prescale_i;
    logic [N-1:0] gpio_o;
    logic [N-1:0] change_o;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    gpio_input_filter #(.NrGPIOs(N), .CntWidth(8), .PrescWidth(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .pad_i       (pad_i),
        .filt_en_i   (filt_en_i),
        .threshold_i (threshold_i),
        .prescale_i  (prescale_i),
        .gpio_o      (gpio_o),
        .change_o    (change_o)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [N-1:0] p, input logic [N-1:0] e,
                       input logic [7:0] t, input logic [15:0] ps,
                       input logic [N-1:0] g, input logic [N-1:0] c);
        vec_t v;
        v.rst = r; v.pad = p; v.en = e; v.thr = t; v.presc = ps;
        v.exp_gpio = g; v.exp_chg = c;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [N-1:0] g, input logic [N-1:0] c);
        total++;
        if (gpio_o !== g || change_o !== c) begin
            bad++;
            $display("FAIL %s: gpio_o=%b change_o=%b, required gpio_o=%b change_o=%b",
                     name, gpio_o, change_o, g, c);
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] p, input logic [N-1:0] e,
                         input logic [7:0] t, input logic [15:0] ps);
        rst_i = r; pad_i = p; filt_en_i = e; threshold_i = t; prescale_i = ps;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b1, 4'h0, 4'h0, 8'd0, 16'd0);

        // 1: reset with pads high, then release in bypass
        for (int i = 0; i < 5; i++) add(1'b1, 4'hF, 4'h0, 8'd0, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'hF, 4'h0, 8'd0, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'hF, 4'h0, 8'd0, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'hF, 4'h0, 8'd0, 16'd0, 4'hF, 4'hF);
        add(1'b0, 4'hF, 4'h0, 8'd0, 16'd0, 4'hF, 4'h0);
        // 2: filter accept, T=4, rises on 6th edge
        add(1'b1, 4'h0, 4'h0, 8'd0, 16'd0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) add(1'b0, 4'h1, 4'h1, 8'd4, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h1, 4'h1, 8'd4, 16'd0, 4'h1, 4'h1);
        add(1'b0, 4'h1, 4'h1, 8'd4, 16'd0, 4'h1, 4'h0);
        // 3: 3-cycle glitch rejected, then a full hold accepts from a cleared count
        add(1'b1, 4'h0, 4'h0, 8'd0, 16'd0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) add(1'b0, 4'h1, 4'h1, 8'd4, 16'd0, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) add(1'b0, 4'h0, 4'h1, 8'd4, 16'd0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) add(1'b0, 4'h1, 4'h1, 8'd4, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h1, 4'h1, 8'd4, 16'd0, 4'h1, 4'h1);
        // 5a: threshold 0 on pin 0 matches bypass pin 3, both directions
        add(1'b1, 4'h0, 4'h0, 8'd0, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd0, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd0, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd0, 16'd0, 4'h9, 4'h9);
        add(1'b0, 4'h9, 4'h1, 8'd0, 16'd0, 4'h9, 4'h0);
        add(1'b0, 4'h0, 4'h1, 8'd0, 16'd0, 4'h9, 4'h0);
        add(1'b0, 4'h0, 4'h1, 8'd0, 16'd0, 4'h9, 4'h0);
        add(1'b0, 4'h0, 4'h1, 8'd0, 16'd0, 4'h0, 4'h9);
        // 6a: pins 0 (filtered T=4) and 3 (bypass) toggle together
        add(1'b1, 4'h0, 4'h0, 8'd0, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h8, 4'h8);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h8, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h8, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h9, 4'h1);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h9, 4'h0);
        // 6b: reset with pin 0 count at 3; afterwards counting restarts at 0
        add(1'b1, 4'h0, 4'h0, 8'd0, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h8, 4'h8);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h8, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h8, 4'h0);
        add(1'b1, 4'h9, 4'h1, 8'd4, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h0, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h8, 4'h8);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h8, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h8, 4'h0);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h9, 4'h1);
        add(1'b0, 4'h9, 4'h1, 8'd4, 16'd0, 4'h9, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].pad, vecs[i].en, vecs[i].thr, vecs[i].presc);
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_gpio, vecs[i].exp_chg);
        end

        // 4: prescale 9, T=2 -> ticks on edges 10,20; accept on edge 20
        drive(1'b1, 4'h0, 4'h0, 8'd0, 16'd0);
        step();
        check("presc_reset", 4'h0, 4'h0);
        drive(1'b0, 4'h1, 4'h1, 8'd2, 16'd9);
        for (int k = 1; k <= 19; k++) begin
            step();
            check($sformatf("presc_wait_e%0d", k), 4'h0, 4'h0);
        end
        step();
        check("presc_accept_e20", 4'h1, 4'h1);
        // pin 1 differs from edge 23; next tick at 30 unless the reload is lowered
        drive(1'b0, 4'h3, 4'h3, 8'd1, 16'd9);
        for (int k = 21; k <= 27; k++) begin
            step();
            check($sformatf("presc_hold_e%0d", k), 4'h1, 4'h0);
        end
        prescale_i = 16'd3;
        step();
        check("presc_lowered_tick_e28", 4'h3, 4'h2);

        // 5b: prescale 1 (ticks on even edges), T=10; count is 6 after edge 14
        drive(1'b1, 4'h0, 4'h0, 8'd0, 16'd0);
        step();
        check("thr_reset", 4'h0, 4'h0);
        drive(1'b0, 4'h1, 4'h1, 8'd10, 16'd1);
        for (int k = 1; k <= 14; k++) begin
            step();
            check($sformatf("thr_count_e%0d", k), 4'h0, 4'h0);
        end
        threshold_i = 8'd5;
        step();
        check("thr_no_tick_e15", 4'h0, 4'h0);
        step();
        check("thr_accept_e16", 4'h1, 4'h1);
        step();
        check("thr_after_e17", 4'h1, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_input_filter.md
Name: gpio_input_filter

Overview:
Per-pin input conditioning stage directly upstream of the GPIO peripheral's gpio_in port. It synchronises raw pad inputs with two flip-flops and optionally debounces each pin with a prescaled stability counter. It emits the filtered level, which drives gpio_in, plus one-cycle change pulses. Configuration comes from static control inputs driven by the SoC control registers.

Parameters:
NrGPIOs, gpio_reg_pkg::GPIOCount, number of pins; must match the GPIO peripheral.
CntWidth, 8, width of the per-pin stability counter and of the threshold.
PrescWidth, 16, width of the shared prescaler counter and of its reload value.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset; synchronous, active-high.
pad_i  in  NrGPIOs  raw asynchronous pad inputs.
filt_en_i  in  NrGPIOs  per-pin filter enable; 0 selects bypass (sync only).
threshold_i  in  CntWidth  number of consecutive differing ticks needed to accept a new level; 0 is treated as 1.
prescale_i  in  PrescWidth  tick period minus 1; 0 gives a tick every cycle.
gpio_o  out  NrGPIOs  filtered level; connects to gpio_in of the GPIO peripheral.
change_o  out  NrGPIOs  one-cycle pulse when the corresponding gpio_o bit changes.

Behaviour:
- Reset (rst_i=1 at an edge): sync stages s1/s2, stable_q (= gpio_o), all cnt_q, presc_q and change_o are cleared to 0. Reset has priority over every other event and aborts any count in progress.
- Synchroniser: s1 <= pad_i; s2 <= s1. These are plain flops with no reset exemption.
- Prescaler (shared by all pins):
  - tick = (presc_q >= prescale_i).
  - On tick, presc_q <= 0; otherwise presc_q <= presc_q + 1.
  - The >= comparison means lowering prescale_i below presc_q wraps on the next cycle, with no runaway count.
- Bypass pin (filt_en_i[i]=0): stable_q[i] <= s2[i] every cycle; cnt_q[i] <= 0. Latency from pad to gpio_o is 3 clock edges.
- Filtered pin (filt_en_i[i]=1), with T = max(threshold_i, 1):
  - If s2[i] == stable_q[i]: cnt_q[i] <= 0. Any glitch shorter than the accept time is discarded.
  - Else if no tick: cnt_q[i] holds.
  - Else if cnt_q[i] + 1 >= T: stable_q[i] <= s2[i] and cnt_q[i] <= 0.
  - Else: cnt_q[i] <= cnt_q[i] + 1.
  - Compare at CntWidth+1 bits so that cnt_q never overflows.
- Latency, filtered pin, prescale_i=0: gpio_o changes 2+T edges after a pad change held stable. With T=1 this equals bypass latency.
- change_o[i] <= (next stable_q[i] != stable_q[i]). It is registered and aligned to the same edge on which gpio_o changes, and high for exactly one cycle.
- Config changes mid-count:
  - A new threshold applies immediately. If cnt_q+1 >= new T, the new level is accepted on the next tick.
  - Disabling a pin clears its count; gpio_o follows s2 from the next edge, pulsing change_o if the levels differ.
  - Enabling a pin starts from cnt_q = 0.
- Simultaneous events on different pins are fully independent; several change_o bits may assert in the same cycle.
- No combinational path from any input to any output.

Test Plan:
1. Reset behaviour: hold rst_i=1 with pad_i all ones for 5 cycles -> gpio_o=0 and change_o=0 throughout. Release reset with filt_en_i=0 -> gpio_o all ones on the 3rd edge after release, with change_o all ones for that one cycle only.
2. Filter accept: pin 0 enabled, threshold_i=4, prescale_i=0, pad 0->1 held -> gpio_o[0] rises exactly 6 edges after the pad edge; change_o[0] pulses once.
3. Glitch rejection: same configuration, pad high for 3 cycles then low -> gpio_o[0] stays 0, change_o[0] never asserts, cnt_q returns to 0.
4. Prescaler: prescale_i=9, threshold_i=2, pad held high -> acceptance occurs on the 2nd tick with a nonzero difference count, within 20–30 cycles. Check the exact edge against a reference model. Then change prescale_i from 9 to 3 while presc_q=7 -> tick on the next cycle.
5. Threshold 0 and mid-count change:
   - threshold_i=0 behaves identically to threshold_i=1.
   - With threshold_i=10 and the count at 6, setting threshold_i=5 -> accepted on the next tick.
6. Per-pin independence and mid-operation reset:
   - Pins 0 and 3 toggle together with different enables -> pin 3 (bypass) updates at 3 edges, pin 0 at 2+T edges.
   - Asserting rst_i mid-count -> all outputs 0 on the next edge and counting restarts from 0.
